// File: rtl/mem_port_arbiter_if.sv
// Signal bundle tying the data-memory arbiter to the core path, the user read port and the memory.
// The slave view belongs to the arbiter; the master view to the requesters and the memory array.
interface mem_port_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic          usr_req;
    logic [AW-1:0] usr_addr;
    logic          usr_ack;
    logic [DW-1:0] usr_rdata;
    logic          stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, usr_req, usr_addr, mem_rdata,
        output core_ack, core_rdata, usr_ack, usr_rdata, stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, usr_req, usr_addr, mem_rdata,
        input  core_ack, core_rdata, usr_ack, usr_rdata, stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: core has priority, an aging counter guarantees the user port progress.
// Optional grant statistics are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       core_gnt_cnt,
    output logic [15:0]       usr_gnt_cnt
`endif
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_C,
        ISSUE_U,
        RESP_C,
        RESP_U
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          grant_core;
    logic          grant_usr;
    logic          mem_en;
    logic          mem_we;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [WW-1:0] wait_cnt;
    logic          core_ack;
    logic          usr_ack;
    logic [DW-1:0] core_rdata;
    logic [DW-1:0] usr_rdata;
    logic          usr_owned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration happens only in IDLE; an access in flight always runs to completion.
    always_comb begin
        next_state = state;
        grant_core = 1'b0;
        grant_usr  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.core_req && (!bus.usr_req || (wait_cnt < WAIT_LIM))) begin
                    grant_core = 1'b1;
                    next_state = ISSUE_C;
                end else if (bus.usr_req) begin
                    grant_usr  = 1'b1;
                    next_state = ISSUE_U;
                end
            end
            ISSUE_C: begin
                mem_en     = 1'b1;
                mem_we     = lat_we;
                next_state = RESP_C;
            end
            ISSUE_U: begin
                mem_en     = 1'b1;
                next_state = RESP_U;
            end
            RESP_C:  next_state = IDLE;
            RESP_U:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign usr_owned = (state == ISSUE_U) || (state == RESP_U);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we     <= 1'b0;
            core_ack   <= 1'b0;
            usr_ack    <= 1'b0;
            core_rdata <= '0;
            usr_rdata  <= '0;
            wait_cnt   <= '0;
        end else begin
            if (grant_core) begin
                lat_we <= bus.core_we;
            end else if (grant_usr) begin
                lat_we <= 1'b0;
            end
            core_ack <= (state == RESP_C);
            usr_ack  <= (state == RESP_U);
            if ((state == RESP_C) && !lat_we) begin
                core_rdata <= bus.mem_rdata;
            end
            if (state == RESP_U) begin
                usr_rdata <= bus.mem_rdata;
            end
            // Age the user request only while someone else holds the memory.
            if (grant_usr) begin
                wait_cnt <= '0;
            end else if (bus.usr_req && !usr_owned && (wait_cnt < WAIT_LIM)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_core) begin
            lat_addr  <= bus.core_addr;
            lat_wdata <= bus.core_wdata;
        end else if (grant_usr) begin
            lat_addr  <= bus.usr_addr;
        end
    end

    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    assign bus.core_ack   = core_ack;
    assign bus.usr_ack    = usr_ack;
    assign bus.core_rdata = core_rdata;
    assign bus.usr_rdata  = usr_rdata;
    assign bus.stall      = bus.core_req & ~core_ack;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_gnt_cnt <= '0;
            usr_gnt_cnt  <= '0;
        end else begin
            if (grant_core) begin
                core_gnt_cnt <= core_gnt_cnt + 16'd1;
            end
            if (grant_usr) begin
                usr_gnt_cnt <= usr_gnt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW       = 6;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] core_gnt_cnt;
    logic [15:0] usr_gnt_cnt;
`endif

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_STATS_EN
        ,
        .core_gnt_cnt (core_gnt_cnt),
        .usr_gnt_cnt  (usr_gnt_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    // Synchronous memory array: read data appears one edge after mem_en.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] mem_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_q;

    // Transaction-level reference: one access at a time, two edges after its grant it completes.
    logic [DW-1:0] ref_mem [64];
    int            m_left;
    bit            m_core;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_wait;
    bit            m_ugrant;
    bit            m_uowned;
    bit            e_cack;
    bit            e_uack;
    logic [DW-1:0] e_crd;
    logic [DW-1:0] e_urd;
    int            n_cgnt;
    int            n_ugnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_wait = 0; e_cack = 0; e_uack = 0;
            e_crd = '0; e_urd = '0; n_cgnt = 0; n_ugnt = 0;
        end else begin
            m_ugrant = 0;
            m_uowned = (m_left > 0) && !m_core;
            e_cack = 0;
            e_uack = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_core) begin
                        e_cack = 1;
                        if (m_we) ref_mem[m_addr] = m_wdata;
                        else      e_crd = ref_mem[m_addr];
                    end else begin
                        e_uack = 1;
                        e_urd = ref_mem[m_addr];
                    end
                end
            end else if (bus.core_req || bus.usr_req) begin
                m_core = bus.core_req && !(bus.usr_req && m_wait >= MAX_WAIT);
                m_left = 2;
                if (m_core) begin
                    m_we = bus.core_we; m_addr = bus.core_addr; m_wdata = bus.core_wdata;
                    n_cgnt++;
                end else begin
                    m_we = 0; m_addr = bus.usr_addr; m_ugrant = 1;
                    n_ugnt++;
                end
            end
            if (m_ugrant) m_wait = 0;
            else if (bus.usr_req && !m_uowned && m_wait < MAX_WAIT) m_wait++;
        end
    end

    always @(negedge clk) begin
        check("core_ack",   bus.core_ack,   e_cack);
        check("usr_ack",    bus.usr_ack,    e_uack);
        check("core_rdata", bus.core_rdata, e_crd);
        check("usr_rdata",  bus.usr_rdata,  e_urd);
        check("stall",      bus.stall,      bus.core_req & ~e_cack);
        check("mem_en",     bus.mem_en,     (m_left == 2));
        check("mem_we",     bus.mem_we,     (m_left == 2) && m_core && m_we);
        if (m_left == 2) check("mem_addr", bus.mem_addr, m_addr);
        if (m_left == 2 && m_core && m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
    end

    task automatic core_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output int lat);
        bus.core_req = 1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            if (bus.core_ack) begin lat = n; break; end
            check("stall_held", bus.stall, 1);
        end
        bus.core_req = 0;
    endtask

    task automatic usr_access(input logic [AW-1:0] a, output int lat);
        bus.usr_req = 1; bus.usr_addr = a;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            check("usr_no_write", bus.mem_we, 0);
            if (bus.usr_ack) begin lat = n; break; end
        end
        bus.usr_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        int lat, ca, ua, nc, nu;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        mem_q = '0;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.usr_req = 0; bus.usr_addr = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_core_ack", bus.core_ack, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_core_rdata", bus.core_rdata, 0);
        rst = 1;
        @(negedge clk); #1;

        // Core write then read back
        core_access(1, 6'd5, 16'hBEEF, lat);
        check("wr_latency", lat, 3);
        core_access(0, 6'd5, 16'h0000, lat);
        check("rd_latency", lat, 3);
        check("rd_data", bus.core_rdata, 16'hBEEF);

        // User read of the same word
        usr_access(6'd5, lat);
        check("usr_latency", lat, 3);
        check("usr_data", bus.usr_rdata, 16'hBEEF);

        // Simultaneous requests with a fresh aging counter: core first
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 6'd5;
        bus.usr_req = 1; bus.usr_addr = 6'd9;
        ca = -1; ua = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            if (bus.core_ack) begin ca = n; bus.core_req = 0; end
            if (bus.usr_ack) begin ua = n; bus.usr_req = 0; end
            if (ca > 0 && ua > 0) break;
        end
        bus.core_req = 0; bus.usr_req = 0;
        check("tie_core_at", ca, 3);
        check("tie_usr_at", ua, 6);
        check("tie_usr_data", bus.usr_rdata, 16'h1009);

        // Both held: two core grants then one user grant, repeating
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 6'd2;
        bus.usr_req = 1; bus.usr_addr = 6'd3;
        nc = 0; nu = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk); #1;
            if (bus.core_ack) nc++;
            if (bus.usr_ack) nu++;
        end
        bus.core_req = 0; bus.usr_req = 0;
        check("held_core_acks", nc, 8);
        check("held_usr_acks", nu, 4);

        // Reset during the issue cycle of a write abandons it
        core_access(1, 6'd7, 16'h5A5A, lat);
        check("pre_wr_latency", lat, 3);
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 6'd7; bus.core_wdata = 16'h1234;
        @(negedge clk); #1;
        check("issue_mem_we", bus.mem_we, 1);
        rst = 0;
        #1;
        check("rst_mem_we_drop", bus.mem_we, 0);
        check("rst_mem_en_drop", bus.mem_en, 0);
        bus.core_req = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_no_ack", bus.core_ack, 0);
        rst = 1;
        @(negedge clk); #1;
        core_access(0, 6'd7, 16'h0000, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", bus.core_rdata, 16'h5A5A);

        core_access(1, 6'd10, 16'h0F0F, lat);
        core_access(0, 6'd10, 16'h0000, lat);
        usr_access(6'd10, lat);
        usr_access(6'd10, lat);
        check("usr_data2", bus.usr_rdata, 16'h0F0F);
`ifdef ARB_STATS_EN
        check("core_gnt_cnt", core_gnt_cnt, 3);
        check("usr_gnt_cnt", usr_gnt_cnt, 2);
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (bus.core_req) begin
                if (bus.core_ack) begin
                    if ($urandom_range(3) == 0) begin
                        bus.core_we = 1'($urandom_range(1));
                        bus.core_addr = 6'($urandom_range(7));
                        bus.core_wdata = 16'($urandom);
                    end else begin
                        bus.core_req = 0;
                    end
                end
            end else if ($urandom_range(2) == 0) begin
                bus.core_req = 1;
                bus.core_we = 1'($urandom_range(1));
                bus.core_addr = 6'($urandom_range(7));
                bus.core_wdata = 16'($urandom);
            end
            if (bus.usr_req) begin
                if (bus.usr_ack) begin
                    if ($urandom_range(3) == 0) bus.usr_addr = 6'($urandom_range(7));
                    else bus.usr_req = 0;
                end
            end else if ($urandom_range(2) == 0) begin
                bus.usr_req = 1;
                bus.usr_addr = 6'($urandom_range(7));
            end
        end
        for (int c = 0; c < 40 && (bus.core_req || bus.usr_req); c++) begin
            @(negedge clk); #1;
            if (bus.core_ack) bus.core_req = 0;
            if (bus.usr_ack) bus.usr_req = 0;
        end
        check("drain_core_req", bus.core_req, 0);
        check("drain_usr_req", bus.usr_req, 0);
        repeat (4) @(negedge clk);
`ifdef ARB_STATS_EN
        check("rand_core_gnt_cnt", core_gnt_cnt, 16'(n_cgnt));
        check("rand_usr_gnt_cnt", usr_gnt_cnt, 16'(n_ugnt));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
